vga_sync_gen: RTL and testbench

Generates VGA 640x480@60 Hz raster timing from the 25 MHz pixel clock produced by the game's clock divider. It drives the horizontal and vertical sync pins and supplies pixel coordinates, a display-enable, and a once-per-frame tick. Bird/pipe rendering and the per-frame game update logic consume these outputs.

---
 rtl/vga_sync_gen.sv | 100 ++++++++++
 tb/tb_vga_sync_gen.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator (640x480@60 Hz at a 25 MHz pixel clock).
// Free-running horizontal/vertical counters drive registered sync pulses, pixel
// coordinates, a display-enable and a once-per-frame tick at the start of
// vertical blanking.
// Optional feature: define VGA_FRAME_CNT_EN to add the 8-bit frame_cnt output.
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       clr,
    output logic       hs,
    output logic       vs,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_tick
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Decode thresholds, pre-sized to the 10-bit counter width.
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] h;
    logic [9:0] v;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       h_wrap;
    logic       tick_next;

    // Next counter values: h wraps at end of line, v advances only on that wrap.
    always_comb begin
        // NOTE: every signal gets a value before any condition, so no path can
        // leave one unassigned and infer a latch.
        h_wrap    = (h == H_LAST);
        h_next    = h + 10'd1;
        v_next    = v;
        if (h_wrap) begin
            h_next = 10'd0;
            v_next = (v == V_LAST) ? 10'd0 : v + 10'd1;
        end
        tick_next = (h_next == 10'd0) && (v_next == V_VIS);
    end

    // Counters and all outputs load together, decoded from the values being
    // loaded this edge so every output describes the same pixel.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            h          <= 10'd0;
            v          <= 10'd0;
            hs         <= 1'b1;
            vs         <= 1'b1;
            video_on   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register here samples the
            // pre-edge values and ordering within the block does not matter.
            h          <= h_next;
            v          <= v_next;
            hs         <= !((h_next >= HS_START) && (h_next < HS_END));
            vs         <= !((v_next >= VS_START) && (v_next < VS_END));
            video_on   <= (h_next < H_VIS) && (v_next < V_VIS);
            frame_tick <= tick_next;
        end
    end

    assign x = h;
    assign y = v;

`ifdef VGA_FRAME_CNT_EN
    // Frame counter steps on the same edge frame_tick rises; wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            frame_cnt <= 8'd0;
        end else if (tick_next) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench for vga_sync_gen.
// Two instances share clk/clr: one with the default 640x480 timing and one with
// a tiny raster so whole frames (and the 8-bit frame counter wrap) fit in a short
// run. Expected outputs come from an arithmetic model based on the number of
// clock edges since reset release.
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       tick;
        logic [7:0] fc;
    } obs_t;

    // Tiny raster for the small instance: 14 x 11 = 154 cycles per frame.
    localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 1;
    localparam int SVV = 5, SVF = 2, SVS = 3, SVB = 1;
    localparam int S_FRAME = (SHV + SHF + SHS + SHB) * (SVV + SVF + SVS + SVB);
    localparam int P3_STEPS = 40000;

    logic clk = 1'b0;
    logic clr = 1'b0;

    logic       s_hs, s_vs, s_von, s_tick;
    logic [9:0] s_x, s_y;
    logic       d_hs, d_vs, d_von, d_tick;
    logic [9:0] d_x, d_y;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] s_fc, d_fc;
`endif

    vga_sync_gen #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
    ) dut_s (
        .clk        (clk),
        .clr        (clr),
        .hs         (s_hs),
        .vs         (s_vs),
        .video_on   (s_von),
        .x          (s_x),
        .y          (s_y),
        .frame_tick (s_tick)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt  (s_fc)
`endif
    );

    vga_sync_gen dut_d (
        .clk        (clk),
        .clr        (clr),
        .hs         (d_hs),
        .vs         (d_vs),
        .video_on   (d_von),
        .x          (d_x),
        .y          (d_y),
        .frame_tick (d_tick)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt  (d_fc)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: n = rising edges seen with clr high since the last reset.
    function automatic obs_t model(input int n, input int hv, input int hf, input int hsw,
                                   input int hb, input int vv, input int vf, input int vsw,
                                   input int vb);
        obs_t o;
        int ht, vt, pos, h, v, tick_pos, ticks;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        if (n == 0) begin
            o = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, von: 1'b0, tick: 1'b0, fc: 8'd0};
            return o;
        end
        pos      = n % (ht * vt);
        h        = pos % ht;
        v        = pos / ht;
        tick_pos = vv * ht;
        ticks    = (n >= tick_pos) ? (n - tick_pos) / (ht * vt) + 1 : 0;
        o.x    = 10'(h);
        o.y    = 10'(v);
        o.hs   = !(h >= hv + hf && h < hv + hf + hsw);
        o.vs   = !(v >= vv + vf && v < vv + vf + vsw);
        o.von  = (h < hv) && (v < vv);
        o.tick = (h == 0) && (v == vv);
`ifdef VGA_FRAME_CNT_EN
        o.fc   = 8'(ticks % 256);
`else
        o.fc   = 8'd0;
`endif
        return o;
    endfunction

    obs_t q_s[$];
    obs_t q_d[$];
    int   edges = 0;
    bit   phase3 = 1'b0;
    bit   done = 1'b0;

    // Advance one clock; new_clr is applied just after the edge (asynchronously).
    task automatic step(input logic new_clr);
        @(posedge clk);
        if (clr) edges++;
        #1;
        clr = new_clr;
        if (!new_clr) edges = 0;
        q_s.push_back(model(edges, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB));
        q_d.push_back(model(edges, 640, 16, 96, 48, 480, 10, 2, 33));
    endtask

    // Stimulus: initial reset, random mid-frame resets, then a long clean run.
    initial begin
        repeat (5) step(1'b0);
        for (int r = 0; r < 8; r++) begin
            int run_len, rst_len;
            run_len = int'($urandom_range(20, 900));
            rst_len = int'($urandom_range(1, 3));
            repeat (run_len) step(1'b1);
            repeat (rst_len) step(1'b0);
        end
        phase3 = 1'b1;
        repeat (P3_STEPS) step(1'b1);
        done = 1'b1;
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int tick_cycles[$];
    bit finished = 1'b0;

    task automatic check(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got x=%0d y=%0d hs=%b vs=%b von=%b tick=%b fc=%0d want x=%0d y=%0d hs=%b vs=%b von=%b tick=%b fc=%0d",
                     name, cyc, got.x, got.y, got.hs, got.vs, got.von, got.tick, got.fc,
                     exp.x, exp.y, exp.hs, exp.vs, exp.von, exp.tick, exp.fc);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, exp);
        end
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard and compares.
    always @(negedge clk) begin
        obs_t got_s, got_d;
        cyc++;
        got_s = '{x: s_x, y: s_y, hs: s_hs, vs: s_vs, von: s_von, tick: s_tick, fc: 8'd0};
        got_d = '{x: d_x, y: d_y, hs: d_hs, vs: d_vs, von: d_von, tick: d_tick, fc: 8'd0};
`ifdef VGA_FRAME_CNT_EN
        got_s.fc = s_fc;
        got_d.fc = d_fc;
`endif
        if (q_s.size() > 0) check("small", got_s, q_s.pop_front());
        if (q_d.size() > 0) check("dflt", got_d, q_d.pop_front());
        if (phase3 && s_tick === 1'b1) tick_cycles.push_back(cyc);
        if (cyc > 60000 && !finished) begin
            check_int("watchdog_done", int'(done), 1);
            finished = 1'b1;
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
        if (done && !finished) begin
            finished = 1'b1;
            check_int("scoreboard_drained", q_s.size() + q_d.size(), 0);
            check_int("tick_count", tick_cycles.size(), (P3_STEPS - SVV * (SHV + SHF + SHS + SHB)) / S_FRAME + 1);
            for (int i = 1; i < tick_cycles.size(); i++)
                check_int("tick_spacing", tick_cycles[i] - tick_cycles[i-1], S_FRAME);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

endmodule
